cpu_apb_bridge: RTL and testbench
=================================

CPU_APB_BRIDGE -- requirements
Module: cpu_apb_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: ACCESS cycles allowed without PREADY before abort (range 1..255).
REQ-002 Ports; clock and reset are listed first:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- Wr_En  in  1  write request from the writeback-stage register
- transEn  in  1  peripheral read request from the writeback-stage register
- MemStrobeW  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word
- ALUResultW  in  32  byte address
- WriteDataW  in  32  store data, right-aligned
- StallW  out  1  freeze the writeback-stage register
- store_done  out  1  one-cycle pulse when a write completes
- load_valid  out  1  one-cycle pulse when read data is valid
- ReadDataP  out  32  captured PRDATA
- bus_err  out  1  one-cycle pulse on a slave error, timeout or misalignment
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  32  APB address
- PWDATA  out  32  APB write data
- PSTRB  out  4  APB byte strobes
- PRDATA  in  32  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB slave error

Function
REQ-003 FSM states are IDLE, SETUP, ACCESS, and the FSM SHALL leave reset in IDLE.
REQ-004 A request is Wr_En=1 or transEn=1 sampled in IDLE; when both are set, the write SHALL win and the read is dropped.
REQ-005 IDLE with an aligned request SHALL go to SETUP: PSEL=1, PENABLE=0, PWRITE=Wr_En, PADDR=ALUResultW; all APB outputs are registered and held until completion.
REQ-006 SETUP SHALL go to ACCESS unconditionally after one cycle: PSEL=1, PENABLE=1.
REQ-007 ACCESS with PREADY=1 SHALL complete the transfer and go to IDLE; PSEL and PENABLE drop on that edge.
REQ-008 ACCESS with PREADY=0 SHALL hold all APB outputs and increment an 8-bit wait counter.
REQ-009 When the wait counter reaches TIMEOUT_CYCLES, the bridge SHALL abort: go to IDLE, pulse bus_err, and assert neither store_done nor load_valid.
REQ-010 StallW SHALL be combinational: 1 in IDLE while an aligned request is present, 1 in SETUP, 1 in ACCESS; 0 in the completion or abort cycle.
REQ-011 Because StallW drops in the completion cycle, the held request SHALL NOT be re-issued; the next request is taken from freshly loaded inputs.
REQ-012 Strobe generation:
- byte: PSTRB = 1 << addr[1:0]
- half: PSTRB = 0011 or 1100, selected by addr[1]
- word: PSTRB = 1111
REQ-013 PWDATA SHALL replicate the data across lanes: byte as {4{WriteDataW[7:0]}}, half as {2{WriteDataW[15:0]}}, word as-is.
REQ-014 A misaligned request (half with addr[0]=1, or word with addr[1:0]!=0) SHALL issue no APB transfer, SHALL pulse bus_err and store_done (write) or load_valid (read) in the request cycle, and SHALL hold StallW=0.
REQ-015 On write completion, store_done SHALL pulse for exactly one cycle, registered on the edge after PREADY is sampled.
REQ-016 On read completion, ReadDataP SHALL capture PRDATA and load_valid SHALL pulse for one cycle on the same edge; ReadDataP holds its value until the next read.
REQ-017 PSLVERR=1 at completion SHALL additionally pulse bus_err; the store_done or load_valid pulse still occurs.

Reset
REQ-018 rst=0 SHALL asynchronously clear the state to IDLE, clear the wait counter, and drive every output to 0 (including PADDR, PWDATA, PSTRB and ReadDataP).
REQ-019 Reset mid-transfer SHALL drop PSEL and PENABLE immediately, with no completion pulses.

Structure
REQ-020 The state encoding, size codes (BYTE, HALF, WORD) and the TIMEOUT default SHALL live in the shared package apb_pkg.
REQ-021 The strobe and lane logic of REQ-012..REQ-014 SHALL be a combinational sub-module apb_strobe_gen.

Verification
REQ-022 Word write to 0x4000_0008, data 0xDEADBEEF, PREADY=1 in the first ACCESS: PSTRB=1111, StallW high for 2 cycles, store_done pulses once.
REQ-023 Byte write to 0x4000_0003, data 0x000000A5: PSTRB=1000, PWDATA=0xA5A5A5A5.
REQ-024 Read from 0x4000_0004, PREADY held low for 3 cycles, PRDATA=0x12345678: StallW high for 5 cycles, ReadDataP=0x12345678, load_valid pulses once.
REQ-025 Read with PREADY held low forever and TIMEOUT_CYCLES=4: abort after 4 ACCESS cycles, bus_err pulses, no load_valid.
REQ-026 Half write to 0x4000_0001: no PSEL, bus_err and store_done pulse in the same cycle, StallW=0.
REQ-027 rst=0 applied in ACCESS: PSEL=0 and StallW=0 with no clock edge, no pulses; after release, the next request runs normally.

Source files
------------

// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the CPU-to-APB bridge:
//   - apb_state_e     : bridge FSM states (IDLE / SETUP / ACCESS)
//   - SIZE_*          : MemStrobeW access-size codes (2'b11 is handled as word)
//   - TIMEOUT_DEFAULT : default number of ACCESS cycles tolerated without PREADY
// ---------------------------------------------------------------------------
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/apb_strobe_gen.sv
// ---------------------------------------------------------------------------
// apb_strobe_gen
// Purely combinational byte-lane logic for the bridge.
// Ports:
//   size       in  2   access size code (byte / half / word, 2'b11 = word)
//   addr_lo    in  2   low address bits of the access
//   wdata      in  32  right-aligned store data
//   strb       out 4   byte strobes for the addressed lanes
//   lane_data  out 32  store data replicated onto every lane
//   misaligned out 1   access does not sit on its natural boundary
// ---------------------------------------------------------------------------
module apb_strobe_gen
  import apb_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  strb,
  output logic [31:0] lane_data,
  output logic        misaligned
);

  logic is_byte;
  logic is_half;

  assign is_byte = (size == SIZE_BYTE);
  assign is_half = (size == SIZE_HALF);

  // Anything that is neither byte nor half (10 and 11) is a word access.
  assign misaligned = is_half ? addr_lo[0] : (is_byte ? 1'b0 : (addr_lo != 2'b00));

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    // A lane is enabled when it is the addressed byte, belongs to the
    // addressed halfword, or always for a word.
    assign strb[gi] = is_byte ? (addr_lo == 2'(gi)) :
                      is_half ? (addr_lo[1] == 1'(gi / 2)) :
                                1'b1;

    // Replicate the right-aligned data so every lane carries the value the
    // slave will pick according to PSTRB.
    assign lane_data[8*gi +: 8] = is_byte ? wdata[7:0] :
                                  is_half ? wdata[8*(gi % 2) +: 8] :
                                            wdata[8*gi +: 8];
  end

endmodule

// File: rtl/cpu_apb_bridge.sv
// ---------------------------------------------------------------------------
// cpu_apb_bridge
// Turns a load/store sitting in the CPU writeback-stage register into a
// single APB transfer, stalling the pipeline until the transfer completes.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   Wr_En / transEn           write / read request (write wins if both)
//   MemStrobeW                access size
//   ALUResultW / WriteDataW   byte address / right-aligned store data
//   StallW                    combinational freeze of the writeback register
//   store_done / load_valid   one-cycle completion pulses
//   ReadDataP                 last captured PRDATA
//   bus_err                   one-cycle pulse: slave error, timeout, misalignment
//   PSEL..PSTRB               registered APB master outputs
//   PRDATA, PREADY, PSLVERR   APB slave response
// ---------------------------------------------------------------------------
module cpu_apb_bridge
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Wr_En,
  input  logic        transEn,
  input  logic [1:0]  MemStrobeW,
  input  logic [31:0] ALUResultW,
  input  logic [31:0] WriteDataW,
  output logic        StallW,
  output logic        store_done,
  output logic        load_valid,
  output logic [31:0] ReadDataP,
  output logic        bus_err,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  output logic [3:0]  PSTRB,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  // The wait counter counts completed no-PREADY ACCESS cycles; the cycle in
  // which it already holds TIMEOUT_CYCLES-1 is the last one allowed, so the
  // abort happens after exactly TIMEOUT_CYCLES ACCESS cycles.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  apb_state_e  state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        psel_q, psel_d;
  logic        penable_q, penable_d;
  logic        pwrite_q, pwrite_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic [3:0]  pstrb_q, pstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        store_done_q, store_done_d;
  logic        load_valid_q, load_valid_d;
  logic        bus_err_q, bus_err_d;

  logic [3:0]  lane_strb;
  logic [31:0] lane_data;
  logic        misaligned;
  logic        req_any;
  logic        aligned_req;
  logic        timeout_hit;

  apb_strobe_gen u_strobe_gen (
    .size       (MemStrobeW),
    .addr_lo    (ALUResultW[1:0]),
    .wdata      (WriteDataW),
    .strb       (lane_strb),
    .lane_data  (lane_data),
    .misaligned (misaligned)
  );

  assign req_any     = Wr_En | transEn;
  assign aligned_req = req_any & ~misaligned;
  assign timeout_hit = (state_q == ST_ACCESS) & ~PREADY & (wait_cnt_q == TIMEOUT_LAST);

  // Released in the completion/abort cycle so the writeback register loads
  // the next instruction on the same edge that retires this one. Gated by
  // rst so reset forces it low without waiting for a clock.
  assign StallW = rst & (((state_q == ST_IDLE) & aligned_req) |
                         (state_q == ST_SETUP) |
                         ((state_q == ST_ACCESS) & ~PREADY & ~timeout_hit));

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    pstrb_d      = pstrb_q;
    rdata_d      = rdata_q;
    store_done_d = 1'b0;
    load_valid_d = 1'b0;
    bus_err_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          if (misaligned) begin
            // Rejected without touching the bus; the pipeline still gets its
            // completion pulse so it never waits on this access.
            bus_err_d = 1'b1;
            if (Wr_En) store_done_d = 1'b1;
            else       load_valid_d = 1'b1;
          end else begin
            state_d    = ST_SETUP;
            wait_cnt_d = 8'd0;
            psel_d     = 1'b1;
            penable_d  = 1'b0;
            pwrite_d   = Wr_En;
            paddr_d    = ALUResultW;
            // Reads keep strobes and write data at zero, as APB requires.
            pwdata_d   = Wr_En ? lane_data : 32'd0;
            pstrb_d    = Wr_En ? lane_strb : 4'd0;
          end
        end
      end

      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end

      ST_ACCESS: begin
        if (PREADY) begin
          state_d   = ST_IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          bus_err_d = PSLVERR;
          if (pwrite_q) begin
            store_done_d = 1'b1;
          end else begin
            load_valid_d = 1'b1;
            rdata_d      = PRDATA;
          end
        end else if (timeout_hit) begin
          state_d   = ST_IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          bus_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      wait_cnt_q   <= 8'd0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= 32'd0;
      pwdata_q     <= 32'd0;
      pstrb_q      <= 4'd0;
      rdata_q      <= 32'd0;
      store_done_q <= 1'b0;
      load_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      pstrb_q      <= pstrb_d;
      rdata_q      <= rdata_d;
      store_done_q <= store_done_d;
      load_valid_q <= load_valid_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign PSEL       = psel_q;
  assign PENABLE    = penable_q;
  assign PWRITE     = pwrite_q;
  assign PADDR      = paddr_q;
  assign PWDATA     = pwdata_q;
  assign PSTRB      = pstrb_q;
  assign ReadDataP  = rdata_q;
  assign store_done = store_done_q;
  assign load_valid = load_valid_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_cpu_apb_bridge.sv
// ---------------------------------------------------------------------------
// tb_cpu_apb_bridge
// Self-checking bench for cpu_apb_bridge: directed vector table, random
// transactions against a transaction-level reference model, and a
// reset-in-ACCESS sequence.
// ---------------------------------------------------------------------------
module tb_cpu_apb_bridge;

  localparam int TB_TIMEOUT = 4;

  logic        clk;
  logic        rst;
  logic        Wr_En;
  logic        transEn;
  logic [1:0]  MemStrobeW;
  logic [31:0] ALUResultW;
  logic [31:0] WriteDataW;
  logic        StallW;
  logic        store_done;
  logic        load_valid;
  logic [31:0] ReadDataP;
  logic        bus_err;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int checks = 0;
  int errors = 0;

  cpu_apb_bridge #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .Wr_En      (Wr_En),
    .transEn    (transEn),
    .MemStrobeW (MemStrobeW),
    .ALUResultW (ALUResultW),
    .WriteDataW (WriteDataW),
    .StallW     (StallW),
    .store_done (store_done),
    .load_valid (load_valid),
    .ReadDataP  (ReadDataP),
    .bus_err    (bus_err),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PSTRB      (PSTRB),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One transaction: request inputs, slave behaviour, and expected results.
  // wait_n = number of ACCESS cycles the slave keeps PREADY low.
  typedef struct {
    logic        wr;
    logic        rd;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          wait_n;
    logic [31:0] prdata;
    logic        slverr;
    int          exp_stall;
    logic        exp_psel;
    logic [3:0]  exp_strb;
    logic [31:0] exp_pwdata;
    int          exp_sd;
    int          exp_lv;
    int          exp_be;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic rd, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int wait_n, input logic [31:0] prdata, input logic slverr,
                              input int exp_stall, input logic exp_psel, input logic [3:0] exp_strb,
                              input logic [31:0] exp_pwdata, input int exp_sd, input int exp_lv,
                              input int exp_be, input logic [31:0] exp_rdata);
    vec_t v;
    v.wr = wr; v.rd = rd; v.size = size; v.addr = addr; v.wdata = wdata;
    v.wait_n = wait_n; v.prdata = prdata; v.slverr = slverr;
    v.exp_stall = exp_stall; v.exp_psel = exp_psel; v.exp_strb = exp_strb;
    v.exp_pwdata = exp_pwdata; v.exp_sd = exp_sd; v.exp_lv = exp_lv;
    v.exp_be = exp_be; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  // Reference model: derives the expected outcome of a whole transaction
  // from the bridge's rules, using sizes in bytes and plain arithmetic.
  function automatic vec_t model(input vec_t v, input logic [31:0] prev_rdata);
    vec_t        r;
    int          nbytes;
    bit          is_wr;
    bit          timed_out;
    logic [31:0] mask;
    logic [31:0] repl;
    logic [3:0]  base;
    r = v;
    r.exp_stall = 0; r.exp_psel = 1'b0; r.exp_strb = 4'd0; r.exp_pwdata = 32'd0;
    r.exp_sd = 0; r.exp_lv = 0; r.exp_be = 0; r.exp_rdata = prev_rdata;
    if (!(v.wr || v.rd)) return r;
    is_wr  = v.wr;
    nbytes = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
    if ((v.addr % nbytes) != 0) begin
      r.exp_be = 1;
      r.exp_sd = is_wr ? 1 : 0;
      r.exp_lv = is_wr ? 0 : 1;
      return r;
    end
    timed_out   = (v.wait_n >= TB_TIMEOUT);
    r.exp_stall = 2 + (timed_out ? TB_TIMEOUT - 1 : v.wait_n);
    r.exp_psel  = 1'b1;
    if (is_wr) begin
      mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
      repl = (nbytes == 1) ? 32'h0101_0101 : (nbytes == 2) ? 32'h0001_0001 : 32'd1;
      r.exp_pwdata = (v.wdata & mask) * repl;
      base = 4'((1 << nbytes) - 1);
      r.exp_strb = base << (v.addr % 4);
    end
    if (timed_out) begin
      r.exp_be = 1;
    end else begin
      r.exp_be = v.slverr ? 1 : 0;
      if (is_wr) r.exp_sd = 1;
      else begin
        r.exp_lv    = 1;
        r.exp_rdata = v.prdata;
      end
    end
    return r;
  endfunction

  // Drives one request (called at a negedge), plays the APB slave, and
  // observes the bridge until two cycles after it releases the pipeline.
  task automatic run_txn(input vec_t v, input string tag);
    int          stall_n  = 0;
    int          sd_n     = 0;
    int          lv_n     = 0;
    int          be_n     = 0;
    int          acc_low  = 0;
    int          tail     = 0;
    int          cyc      = 0;
    bit          released = 0;
    logic        psel_seen = 1'b0;
    logic        s_pwrite  = 1'b0;
    logic [31:0] s_paddr   = 32'd0;
    logic [31:0] s_pwdata  = 32'd0;
    logic [3:0]  s_pstrb   = 4'd0;

    Wr_En      = v.wr;
    transEn    = v.rd;
    MemStrobeW = v.size;
    ALUResultW = v.addr;
    WriteDataW = v.wdata;
    PRDATA     = v.prdata;
    while (tail < 2 && cyc < 40) begin
      PREADY  = PSEL && PENABLE && (acc_low >= v.wait_n);
      PSLVERR = PREADY ? v.slverr : 1'b0;
      #1;
      if (StallW) stall_n++;
      if (PSEL && !PENABLE) begin
        psel_seen = 1'b1;
        s_pwrite  = PWRITE;
        s_paddr   = PADDR;
        s_pwdata  = PWDATA;
        s_pstrb   = PSTRB;
      end
      if (store_done) sd_n++;
      if (load_valid) lv_n++;
      if (bus_err)    be_n++;
      if (PSEL && PENABLE && !PREADY) acc_low++;
      if (released) tail++;
      else if (!StallW) released = 1;
      @(negedge clk);
      if (released) begin
        Wr_En   = 1'b0;
        transEn = 1'b0;
      end
      cyc++;
    end
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    checks++;
    if (cyc >= 40) begin
      errors++;
      $display("FAIL %s txn_bound: got %0d cycles required fewer than 40", tag, cyc);
    end
    check({tag, " stall_cycles"}, 32'(stall_n), 32'(v.exp_stall));
    check({tag, " psel_seen"}, 32'(psel_seen), 32'(v.exp_psel));
    if (v.exp_psel) begin
      check({tag, " paddr"}, s_paddr, v.addr);
      check({tag, " pwrite"}, 32'(s_pwrite), 32'(v.wr));
      check({tag, " pstrb"}, 32'(s_pstrb), 32'(v.exp_strb));
      check({tag, " pwdata"}, s_pwdata, v.exp_pwdata);
    end
    check({tag, " store_done"}, 32'(sd_n), 32'(v.exp_sd));
    check({tag, " load_valid"}, 32'(lv_n), 32'(v.exp_lv));
    check({tag, " bus_err"}, 32'(be_n), 32'(v.exp_be));
    check({tag, " ReadDataP"}, ReadDataP, v.exp_rdata);
    $display("txn %s wr=%0b rd=%0b size=%0d addr=%08h wait=%0d stall=%0d sd=%0d lv=%0d be=%0d rdata=%08h",
             tag, v.wr, v.rd, v.size, v.addr, v.wait_n, stall_n, sd_n, lv_n, be_n, ReadDataP);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        tbl[11];
    vec_t        v;
    logic [31:0] rd_prev;
    int          sel;
    int          k;
    int          pulses;

    // addr 0x40000008 word write, PREADY at once
    tbl[0]  = mk(1, 0, 2'b10, 32'h4000_0008, 32'hDEAD_BEEF, 0, 32'h0, 0,
                 2, 1, 4'b1111, 32'hDEAD_BEEF, 1, 0, 0, 32'h0);
    // byte write to lane 3
    tbl[1]  = mk(1, 0, 2'b00, 32'h4000_0003, 32'h0000_00A5, 0, 32'h0, 0,
                 2, 1, 4'b1000, 32'hA5A5_A5A5, 1, 0, 0, 32'h0);
    // word read, PREADY low for 3 ACCESS cycles
    tbl[2]  = mk(0, 1, 2'b10, 32'h4000_0004, 32'h0, 3, 32'h1234_5678, 0,
                 5, 1, 4'b0000, 32'h0, 0, 1, 0, 32'h1234_5678);
    // read that never gets PREADY: abort after 4 ACCESS cycles
    tbl[3]  = mk(0, 1, 2'b10, 32'h4000_0010, 32'h0, 1000, 32'hFFFF_FFFF, 0,
                 5, 1, 4'b0000, 32'h0, 0, 0, 1, 32'h1234_5678);
    // misaligned half write: no transfer, bus_err + store_done
    tbl[4]  = mk(1, 0, 2'b01, 32'h4000_0001, 32'h0000_1234, 0, 32'h0, 0,
                 0, 0, 4'b0000, 32'h0, 1, 0, 1, 32'h1234_5678);
    // write and read together: write wins, upper halfword
    tbl[5]  = mk(1, 1, 2'b01, 32'h4000_0002, 32'h0000_BEEF, 1, 32'h5555_5555, 0,
                 3, 1, 4'b1100, 32'hBEEF_BEEF, 1, 0, 0, 32'h1234_5678);
    // byte read with slave error: data still captured
    tbl[6]  = mk(0, 1, 2'b00, 32'h4000_0001, 32'h0, 2, 32'hCAFE_F00D, 1,
                 4, 1, 4'b0000, 32'h0, 0, 1, 1, 32'hCAFE_F00D);
    // misaligned word read: no transfer, bus_err + load_valid, data kept
    tbl[7]  = mk(0, 1, 2'b10, 32'h4000_0006, 32'h0, 0, 32'h1111_1111, 0,
                 0, 0, 4'b0000, 32'h0, 0, 1, 1, 32'hCAFE_F00D);
    // size code 11 acts as word; slave error on write
    tbl[8]  = mk(1, 0, 2'b11, 32'h4000_000C, 32'h0102_0304, 0, 32'h0, 1,
                 2, 1, 4'b1111, 32'h0102_0304, 1, 0, 1, 32'hCAFE_F00D);
    // PREADY would arrive one cycle too late: abort wins
    tbl[9]  = mk(1, 0, 2'b10, 32'h4000_0020, 32'h7777_7777, 4, 32'h0, 0,
                 5, 1, 4'b1111, 32'h7777_7777, 0, 0, 1, 32'hCAFE_F00D);
    // idle slot: nothing happens
    tbl[10] = mk(0, 0, 2'b10, 32'h4000_0030, 32'h0, 0, 32'h0, 0,
                 0, 0, 4'b0000, 32'h0, 0, 0, 0, 32'hCAFE_F00D);

    // Reset with a request present: everything, including StallW, is 0.
    rst = 1'b0; Wr_En = 1'b1; transEn = 1'b0; MemStrobeW = 2'b10;
    ALUResultW = 32'h4000_0000; WriteDataW = 32'hFFFF_FFFF;
    PRDATA = 32'h0; PREADY = 1'b0; PSLVERR = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset StallW", 32'(StallW), 32'd0);
    check("reset PSEL", 32'(PSEL), 32'd0);
    check("reset PENABLE", 32'(PENABLE), 32'd0);
    check("reset PWRITE", 32'(PWRITE), 32'd0);
    check("reset PADDR", PADDR, 32'd0);
    check("reset PWDATA", PWDATA, 32'd0);
    check("reset PSTRB", 32'(PSTRB), 32'd0);
    check("reset ReadDataP", ReadDataP, 32'd0);
    check("reset pulses", 32'({store_done, load_valid, bus_err}), 32'd0);
    @(negedge clk);
    Wr_En = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_txn(tbl[i], $sformatf("vec%0d", i));
    rd_prev = tbl[10].exp_rdata;

    for (int i = 0; i < 80; i++) begin
      v = mk(0, 0, 2'b00, 32'h0, 32'h0, 0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 0, 0, 0, 32'h0);
      sel       = $urandom_range(0, 5);
      v.wr      = (sel == 1) || (sel == 2) || (sel == 3);
      v.rd      = (sel == 1) || (sel == 4) || (sel == 5);
      v.size    = 2'($urandom_range(0, 3));
      v.addr    = 32'h4000_0000 | ($urandom & 32'h0000_0FFF);
      v.wdata   = $urandom;
      v.wait_n  = $urandom_range(0, 5);
      v.prdata  = $urandom;
      v.slverr  = ($urandom_range(0, 3) == 0);
      v = model(v, rd_prev);
      run_txn(v, $sformatf("rnd%0d", i));
      rd_prev = v.exp_rdata;
    end

    // Reset while the bridge sits in ACCESS waiting for PREADY.
    Wr_En = 1'b0; transEn = 1'b1; MemStrobeW = 2'b10;
    ALUResultW = 32'h4000_0040; PREADY = 1'b0; PSLVERR = 1'b0;
    k = 0;
    while (!(PSEL && PENABLE) && k < 10) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("rst_mid reached ACCESS", 32'(PSEL && PENABLE), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check("rst_mid PSEL", 32'(PSEL), 32'd0);
    check("rst_mid PENABLE", 32'(PENABLE), 32'd0);
    check("rst_mid StallW", 32'(StallW), 32'd0);
    check("rst_mid ReadDataP", ReadDataP, 32'd0);
    pulses = 0;
    repeat (2) begin
      @(negedge clk);
      #1;
      pulses += int'(store_done) + int'(load_valid) + int'(bus_err);
    end
    check("rst_mid pulses", 32'(pulses), 32'd0);
    $display("txn rst_mid reset asserted in ACCESS psel=%0b stall=%0b pulses=%0d", PSEL, StallW, pulses);
    @(negedge clk);
    transEn = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rd_prev = 32'd0;

    v = mk(1, 0, 2'b01, 32'h4000_0046, 32'h0000_ABCD, 1, 32'h0, 0, 0, 0, 4'h0, 32'h0, 0, 0, 0, 32'h0);
    v = model(v, rd_prev);
    run_txn(v, "post_rst_wr");
    rd_prev = v.exp_rdata;
    v = mk(0, 1, 2'b10, 32'h4000_0048, 32'h0, 2, 32'h0BAD_CAFE, 0, 0, 0, 4'h0, 32'h0, 0, 0, 0, 32'h0);
    v = model(v, rd_prev);
    run_txn(v, "post_rst_rd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
